// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm ringing logic.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2,
    DONE    = 2'd3
  } ring_state_t;

  localparam int SNOOZE_SEC_DEF   = 540;  // 9 minutes of seconds-ticks
  localparam int RING_TIMEOUT_DEF = 60;   // ring this long before auto-snooze

endpackage

// File: rtl/sec_down_counter.sv
// Loadable seconds countdown: load wins over clear, decrements on tick, holds at 0.
module sec_down_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count: load, clear, or saturating decrement on the seconds tick.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (clr)
      cnt_d = '0;
    else if (tick && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Turns the alarm_triggered level into a ringing session: beep pattern,
// snooze countdown with a per-session limit, and ring auto-timeout.
module alarm_ring_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SEC       = SNOOZE_SEC_DEF,
  parameter int RING_TIMEOUT_SEC = RING_TIMEOUT_DEF,
  parameter int MAX_SNOOZES      = 3,
  parameter int CNT_W            = 10
) (
  input  logic             clk_pi,
  input  logic             rst_n_pi,
  input  logic             sec_tick_pi,
  input  logic             beat_tick_pi,
  input  logic             alarm_triggered_pi,
  input  logic             snooze_pi,
  output logic             buzzer_po,
  output logic             ringing_po,
  output logic             snoozing_po,
  output logic [CNT_W-1:0] snooze_remaining_po,
  output logic [1:0]       snooze_count_po
);

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TIMEOUT_SEC - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SEC);
  localparam logic [1:0]       SNZ_MAX     = 2'(MAX_SNOOZES);

  ring_state_t      state_d, state_q;
  logic [CNT_W-1:0] ring_cnt_d, ring_cnt_q;
  logic [1:0]       snooze_count_d, snooze_count_q;
  logic             beep_phase_d, beep_phase_q;
  logic             ringing_d, ringing_q;
  logic             snoozing_d, snoozing_q;
  logic             trig_prev_q;
  logic             rem_load, rem_clr, rem_zero;
  logic [CNT_W-1:0] snooze_rem;
  logic             trig_rise, timeout, can_snooze;

  assign trig_rise  = alarm_triggered_pi && !trig_prev_q;
  assign timeout    = sec_tick_pi && (ring_cnt_q == RING_LAST);
  assign can_snooze = (snooze_count_q < SNZ_MAX);

  // Snooze remaining time; cleared whenever the session leaves SNOOZE early
  // so the display output reads 0 outside SNOOZE without extra muxing.
  sec_down_counter #(.CNT_W(CNT_W)) u_snooze_rem (
    .clk      (clk_pi),
    .rst_n    (rst_n_pi),
    .clr      (rem_clr),
    .load     (rem_load),
    .load_val (SNOOZE_LOAD),
    .tick     (sec_tick_pi && state_q == SNOOZE),
    .cnt      (snooze_rem),
    .zero     (rem_zero)
  );

  // Next-state and datapath; a dropped alarm level overrides every other event.
  always_comb begin
    state_d        = state_q;
    ring_cnt_d     = ring_cnt_q;
    snooze_count_d = snooze_count_q;
    beep_phase_d   = beep_phase_q;
    rem_load       = 1'b0;
    rem_clr        = 1'b0;

    if (!alarm_triggered_pi) begin
      state_d        = IDLE;
      ring_cnt_d     = '0;
      snooze_count_d = '0;
      beep_phase_d   = 1'b0;
      rem_clr        = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (trig_rise) begin
          state_d        = RINGING;
          ring_cnt_d     = '0;
          beep_phase_d   = 1'b1;
          snooze_count_d = '0;
        end
        RINGING: begin
          if (beat_tick_pi) beep_phase_d = !beep_phase_q;
          if (sec_tick_pi && ring_cnt_q != RING_LAST) ring_cnt_d = ring_cnt_q + 1'b1;
          // Button and timeout together count as a single snooze.
          if ((snooze_pi || timeout) && can_snooze) begin
            state_d        = SNOOZE;
            rem_load       = 1'b1;
            snooze_count_d = snooze_count_q + 1'b1;
            ring_cnt_d     = '0;
            beep_phase_d   = 1'b0;
          end else if (timeout) begin
            state_d      = DONE;
            ring_cnt_d   = '0;
            beep_phase_d = 1'b0;
          end
        end
        SNOOZE: begin
          // rem_zero also covers a zero-length snooze configuration.
          if (rem_zero || (sec_tick_pi && snooze_rem == CNT_W'(1))) begin
            state_d      = RINGING;
            ring_cnt_d   = '0;
            beep_phase_d = 1'b1;
          end
        end
        DONE: ;  // silent until the alarm level drops
        default: state_d = IDLE;
      endcase
    end

    ringing_d  = (state_d == RINGING);
    snoozing_d = (state_d == SNOOZE);
  end

  // State, counters and registered outputs. trig_prev resets high so a level
  // already present when reset releases is not treated as a new alarm.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      state_q        <= IDLE;
      ring_cnt_q     <= '0;
      snooze_count_q <= '0;
      beep_phase_q   <= 1'b0;
      ringing_q      <= 1'b0;
      snoozing_q     <= 1'b0;
      trig_prev_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      ring_cnt_q     <= ring_cnt_d;
      snooze_count_q <= snooze_count_d;
      beep_phase_q   <= beep_phase_d;
      ringing_q      <= ringing_d;
      snoozing_q     <= snoozing_d;
      trig_prev_q    <= alarm_triggered_pi;
    end
  end

  assign buzzer_po           = beep_phase_q;
  assign ringing_po          = ringing_q;
  assign snoozing_po         = snoozing_q;
  assign snooze_remaining_po = snooze_rem;
  assign snooze_count_po     = snooze_count_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with short snooze/timeout lengths.
module tb_alarm_ring_ctrl;

  localparam int CNT_W = 10;

  logic             clk_pi = 1'b0;
  logic             rst_n_pi = 1'b0;
  logic             sec_tick_pi = 1'b0;
  logic             beat_tick_pi = 1'b0;
  logic             alarm_triggered_pi = 1'b0;
  logic             snooze_pi = 1'b0;
  logic             buzzer_po;
  logic             ringing_po;
  logic             snoozing_po;
  logic [CNT_W-1:0] snooze_remaining_po;
  logic [1:0]       snooze_count_po;

  int n_tests = 0;
  int n_fail  = 0;

  alarm_ring_ctrl #(
    .SNOOZE_SEC       (5),
    .RING_TIMEOUT_SEC (4),
    .MAX_SNOOZES      (3),
    .CNT_W            (CNT_W)
  ) dut (
    .clk_pi              (clk_pi),
    .rst_n_pi            (rst_n_pi),
    .sec_tick_pi         (sec_tick_pi),
    .beat_tick_pi        (beat_tick_pi),
    .alarm_triggered_pi  (alarm_triggered_pi),
    .snooze_pi           (snooze_pi),
    .buzzer_po           (buzzer_po),
    .ringing_po          (ringing_po),
    .snoozing_po         (snoozing_po),
    .snooze_remaining_po (snooze_remaining_po),
    .snooze_count_po     (snooze_count_po)
  );

  always #5 clk_pi = ~clk_pi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given pulses; returns 1 time unit after the edge.
  task automatic cyc(input logic sec, input logic beat, input logic snz);
    sec_tick_pi  = sec;
    beat_tick_pi = beat;
    snooze_pi    = snz;
    @(posedge clk_pi);
    #1;
    sec_tick_pi  = 1'b0;
    beat_tick_pi = 1'b0;
    snooze_pi    = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic rng, input logic snz, input logic buz,
                         input int rem, input int cnt);
    chk({tag, ".ringing"},  32'(ringing_po),          32'(rng));
    chk({tag, ".snoozing"}, 32'(snoozing_po),         32'(snz));
    chk({tag, ".buzzer"},   32'(buzzer_po),           32'(buzz_fix(buz)));
    chk({tag, ".rem"},      32'(snooze_remaining_po), 32'(rem));
    chk({tag, ".count"},    32'(snooze_count_po),     32'(cnt));
  endtask

  function automatic logic buzz_fix(input logic b);
    return b;
  endfunction

  initial begin
    // Reset state
    repeat (2) @(posedge clk_pi);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n_pi = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk_all("idle", 0, 0, 0, 0, 0);

    // Basic ring: buzzer starts high and toggles on beats
    alarm_triggered_pi = 1'b1;
    cyc(0, 0, 0);
    chk_all("ring_entry", 1, 0, 1, 0, 0);
    cyc(0, 1, 0); chk("beat1", 32'(buzzer_po), 0);
    cyc(0, 1, 0); chk("beat2", 32'(buzzer_po), 1);
    cyc(0, 0, 0); chk("nobeat", 32'(buzzer_po), 1);

    // Manual snooze; button inside SNOOZE is ignored
    cyc(0, 0, 1);
    chk_all("snooze1", 0, 1, 0, 5, 1);
    cyc(1, 0, 1);
    chk_all("snooze_btn_ignored", 0, 1, 0, 4, 1);
    repeat (3) cyc(1, 0, 0);
    chk_all("snooze_rem1", 0, 1, 0, 1, 1);
    cyc(1, 0, 0);
    chk_all("snooze_expire", 1, 0, 1, 0, 1);

    // Use up the remaining snoozes
    cyc(0, 0, 1);
    chk_all("snooze2", 0, 1, 0, 5, 2);
    repeat (5) cyc(1, 0, 0);
    cyc(0, 0, 1);
    chk_all("snooze3", 0, 1, 0, 5, 3);
    repeat (5) cyc(1, 0, 0);
    chk_all("ring_after3", 1, 0, 1, 0, 3);

    // Fourth snooze ignored, then timeout ends the session
    cyc(0, 0, 1);
    chk_all("snooze4_ignored", 1, 0, 1, 0, 3);
    repeat (3) cyc(1, 0, 0);
    chk("pre_timeout.ringing", 32'(ringing_po), 1);
    cyc(1, 0, 0);
    chk_all("done", 0, 0, 0, 0, 3);
    cyc(1, 1, 1);
    chk_all("done_hold", 0, 0, 0, 0, 3);
    alarm_triggered_pi = 1'b0;
    cyc(0, 0, 0);
    chk_all("done_to_idle", 0, 0, 0, 0, 0);

    // Auto-snooze after 4 seconds of ringing
    alarm_triggered_pi = 1'b1;
    cyc(0, 0, 0);
    chk_all("ring2", 1, 0, 1, 0, 0);
    repeat (3) cyc(1, 0, 0);
    chk("auto_pre.ringing", 32'(ringing_po), 1);
    cyc(1, 0, 0);
    chk_all("auto_snooze", 0, 1, 0, 5, 1);
    repeat (5) cyc(1, 0, 0);
    chk_all("auto_back", 1, 0, 1, 0, 1);

    // Button and timeout in the same cycle count as one snooze
    repeat (3) cyc(1, 0, 0);
    cyc(1, 1, 1);
    chk_all("snz_plus_timeout", 0, 1, 0, 5, 2);

    // Dismiss has priority over snooze/sec/beat in the same cycle
    alarm_triggered_pi = 1'b0;
    cyc(1, 1, 1);
    chk_all("dismiss", 0, 0, 0, 0, 0);

    // Async reset mid-SNOOZE, then no ring while the level stays high
    alarm_triggered_pi = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk_all("pre_reset", 0, 1, 0, 5, 1);
    #2 rst_n_pi = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0);
    #1 rst_n_pi = 1'b1;
    repeat (3) cyc(1, 1, 0);
    chk_all("post_reset_high", 0, 0, 0, 0, 0);
    alarm_triggered_pi = 1'b0;
    cyc(0, 0, 0);
    alarm_triggered_pi = 1'b1;
    cyc(0, 0, 0);
    chk_all("rearm", 1, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
